// File: rtl/ahb_sram_ctrl.sv
// rtl/ahb_sram_ctrl.sv - AHB-Lite slave bridging to a single-port synchronous SRAM
module ahb_sram_ctrl #(
    parameter int SZ = 64,
    parameter int AW = 12
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            HSEL,
    input  logic [31:0]     HADDR,
    input  logic [1:0]      HTRANS,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [SZ-1:0]   HWDATA,
    input  logic            HREADY,
    output logic            HREADYOUT,
    output logic [SZ-1:0]   HRDATA,
    output logic            SRAM_CS,
    output logic            SRAM_WE,
    output logic [AW-1:0]   SRAM_ADDR,
    output logic [SZ/8-1:0] SRAM_BE,
    output logic [SZ-1:0]   SRAM_WDATA,
    input  logic [SZ-1:0]   SRAM_RDATA
);
    localparam int NB = SZ / 8;
    localparam int L  = $clog2(NB);
    localparam logic [2:0] SIZE_MAX = 3'(L);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_WHOLD} state_t;

    state_t          state;
    state_t          state_nx;
    logic [AW-1:0]   addr_q;
    logic [NB-1:0]   be_q;
    logic            write_q;

    logic            accept;
    logic            read_pending;
    logic            hold;
    logic [AW-1:0]   word_addr;
    logic [2:0]      size_c;
    logic [L-1:0]    offset;
    logic [NB-1:0]   be_c;
    logic            cs_c;
    logic            we_c;
    logic [AW-1:0]   addr_c;
    logic [NB-1:0]   be_out_c;
    logic            unused;

    assign accept       = HSEL & HTRANS[1] & HREADY;
    assign read_pending = HSEL & HTRANS[1] & ~HWRITE;
    assign word_addr    = HADDR[AW+L-1:L];
    assign offset       = HADDR[L-1:0];
    assign unused       = &{1'b0, HTRANS[0], HADDR[31:AW+L]};

    // A lane is enabled when it sits in the same naturally aligned 2^size block as the offset.
    always_comb begin
        be_c   = '0;
        size_c = (HSIZE > SIZE_MAX) ? SIZE_MAX : HSIZE;
        for (int i = 0; i < NB; i++) begin
            be_c[i] = ((L'(i) >> size_c) == (offset >> size_c));
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q  <= '0;
            be_q    <= '0;
            write_q <= 1'b0;
        end else if (accept) begin
            addr_q  <= word_addr;
            be_q    <= be_c;
            write_q <= HWRITE;
        end
    end

    // The SRAM port is shared: a write data phase owns it, so an overlapping read is held one cycle.
    always_comb begin
        state_nx = accept ? (HWRITE ? S_WRITE : S_READ) : S_IDLE;
        hold     = 1'b0;
        if (state == S_WRITE && read_pending) begin
            hold     = 1'b1;
            state_nx = S_WHOLD;
        end

        cs_c     = 1'b0;
        we_c     = 1'b0;
        addr_c   = word_addr;
        be_out_c = '0;
        if (state == S_WRITE) begin
            cs_c     = write_q;
            we_c     = write_q;
            addr_c   = addr_q;
            be_out_c = be_q;
        end else if (accept && !HWRITE) begin
            cs_c = 1'b1;
        end
    end

    assign SRAM_CS    = cs_c & HRESETn;
    assign SRAM_WE    = we_c & HRESETn;
    assign SRAM_ADDR  = addr_c;
    assign SRAM_BE    = be_out_c;
    assign SRAM_WDATA = HWDATA;
    assign HREADYOUT  = ~hold;
    assign HRDATA     = (state == S_READ) ? SRAM_RDATA : '0;

endmodule
